// File: rtl/satalnk_rmcont_mw.sv
// SATA link receive CONT-removal stage: drops/expands P_CONT runs and P_ALIGN
// across NW lanes per beat, with orphan-CONT detection and a suppression counter.
module satalnk_rmcont_mw #(
  parameter int NW             = 2,
  parameter int OPT_REPEAT     = 0,
  parameter int OPT_DROP_ALIGN = 1,
  parameter int OPT_LOWPOWER   = 0,
  parameter int CW             = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  input  logic [NW-1:0]     i_primitive,
  input  logic [32*NW-1:0]  i_data,
  output logic              o_valid,
  output logic [NW-1:0]     o_keep,
  output logic [NW-1:0]     o_primitive,
  output logic [32*NW-1:0]  o_data,
  output logic              o_cont_active,
  output logic              o_err_orphan,
  output logic [CW-1:0]     o_nsuppressed
);

  localparam logic [31:0]   P_ALIGN = 32'h7B4A_4ABC;
  localparam logic [31:0]   P_CONT  = 32'h9999_AA7C;
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic             active_q, active_d;
  logic             have_last_q, have_last_d;
  logic [31:0]      last_q, last_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic [NW-1:0]    keep_q, keep_d;
  logic [NW-1:0]    prim_q, prim_d;
  logic [32*NW-1:0] data_q, data_d;
  logic             orphan_q, orphan_d;

  logic             act_s, have_s, orphan_s;
  logic [31:0]      last_s;
  logic [3:0]       nsup_s;
  logic [CW+3:0]    sum_s;
  logic [NW-1:0]    keep_s, prim_s;
  logic [32*NW-1:0] data_s;

  // Lane-serial evaluation: each lane sees the held state left by the previous lane.
  always_comb begin
    act_s    = active_q;
    have_s   = have_last_q;
    last_s   = last_q;
    orphan_s = 1'b0;
    nsup_s   = 4'd0;
    keep_s   = '0;
    prim_s   = '0;
    data_s   = '0;
    for (int k = 0; k < NW; k++) begin
      if (i_primitive[k] && (i_data[32*k +: 32] == P_ALIGN)) begin
        keep_s[k]          = (OPT_DROP_ALIGN == 0);
        prim_s[k]          = 1'b1;
        data_s[32*k +: 32] = i_data[32*k +: 32];
      end else if (i_primitive[k] && (i_data[32*k +: 32] == P_CONT)) begin
        prim_s[k]          = 1'b1;
        data_s[32*k +: 32] = i_data[32*k +: 32];
        if (have_s) begin
          act_s = 1'b1;
          if (OPT_REPEAT != 0) begin
            keep_s[k]          = 1'b1;
            data_s[32*k +: 32] = last_s;
          end else begin
            nsup_s = nsup_s + 4'd1;
          end
        end else begin
          orphan_s = 1'b1;
        end
      end else if (i_primitive[k]) begin
        act_s              = 1'b0;
        have_s             = 1'b1;
        last_s             = i_data[32*k +: 32];
        keep_s[k]          = 1'b1;
        prim_s[k]          = 1'b1;
        data_s[32*k +: 32] = i_data[32*k +: 32];
      end else if (act_s) begin
        if (OPT_REPEAT != 0) begin
          keep_s[k]          = 1'b1;
          prim_s[k]          = 1'b1;
          data_s[32*k +: 32] = last_s;
        end else begin
          data_s[32*k +: 32] = i_data[32*k +: 32];
          nsup_s             = nsup_s + 4'd1;
        end
      end else begin
        keep_s[k]          = 1'b1;
        data_s[32*k +: 32] = i_data[32*k +: 32];
      end
      if ((OPT_LOWPOWER != 0) && !keep_s[k]) begin
        data_s[32*k +: 32] = 32'd0;
      end else begin
        data_s[32*k +: 32] = data_s[32*k +: 32];
      end
    end
    sum_s = {4'd0, cnt_q} + {{CW{1'b0}}, nsup_s};
  end

  // Commit lane results only for valid beats; idle cycles hold all state.
  always_comb begin
    active_d    = active_q;
    have_last_d = have_last_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    valid_d     = 1'b0;
    keep_d      = '0;
    prim_d      = '0;
    data_d      = '0;
    orphan_d    = 1'b0;
    if (i_valid) begin
      active_d    = act_s;
      have_last_d = have_s;
      last_d      = last_s;
      valid_d     = |keep_s;
      keep_d      = keep_s;
      prim_d      = prim_s;
      data_d      = data_s;
      orphan_d    = orphan_s;
      if (sum_s > {4'd0, CNT_MAX}) begin
        cnt_d = CNT_MAX;
      end else begin
        cnt_d = sum_s[CW-1:0];
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      active_q    <= 1'b0;
      have_last_q <= 1'b0;
      last_q      <= 32'd0;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      keep_q      <= '0;
      prim_q      <= '0;
      data_q      <= '0;
      orphan_q    <= 1'b0;
    end else begin
      active_q    <= active_d;
      have_last_q <= have_last_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      keep_q      <= keep_d;
      prim_q      <= prim_d;
      data_q      <= data_d;
      orphan_q    <= orphan_d;
    end
  end

  assign o_valid       = valid_q;
  assign o_keep        = keep_q;
  assign o_primitive   = prim_q;
  assign o_data        = data_q;
  assign o_cont_active = active_q;
  assign o_err_orphan  = orphan_q;
  assign o_nsuppressed = cnt_q;

endmodule

// File: tb/tb_satalnk_rmcont_mw.sv
// Bench for satalnk_rmcont_mw: four configurations share one directed stream and are
// checked every cycle against a word-stream model, plus hand-computed literals.
module tb_satalnk_rmcont_mw;

  localparam logic [31:0] P_ALIGN = 32'h7B4A_4ABC;
  localparam logic [31:0] P_CONT  = 32'h9999_AA7C;
  localparam logic [31:0] P_HOLD  = 32'hD5D5_AA7C;
  localparam logic [31:0] P_SYNC  = 32'hB5B5_957C;
  localparam logic [31:0] P_XRDY  = 32'h5757_B57C;

  typedef struct {
    bit          v;
    logic [1:0]  k;
    logic [1:0]  p;
    logic [63:0] d;
    bit          a;
    bit          o;
    int          c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vin = 1'b0;
  logic [1:0]  pin = 2'b00;
  logic [63:0] din = 64'd0;

  logic        ov[4];
  logic [1:0]  ok[4];
  logic [1:0]  op[4];
  logic [63:0] od[4];
  logic        oa[4];
  logic        oe[4];
  logic [15:0] oc0, oc1, oc3;
  logic [3:0]  oc2;

  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;
  exp_t en[4];
  exp_t ec[4];
  bit          m_act[4];
  bit          m_have[4];
  logic [31:0] m_last[4];
  int          m_cnt[4];

  always #5 clk = ~clk;

  // dut0: drop mode; dut1: repeat mode; dut2: drop mode, 4-bit counter; dut3: low-power, ALIGN kept
  satalnk_rmcont_mw #(.NW(2), .OPT_REPEAT(0), .OPT_DROP_ALIGN(1), .OPT_LOWPOWER(0), .CW(16)) u_drop (
    .i_clk(clk), .i_reset(rst), .i_valid(vin), .i_primitive(pin), .i_data(din),
    .o_valid(ov[0]), .o_keep(ok[0]), .o_primitive(op[0]), .o_data(od[0]),
    .o_cont_active(oa[0]), .o_err_orphan(oe[0]), .o_nsuppressed(oc0));
  satalnk_rmcont_mw #(.NW(2), .OPT_REPEAT(1), .OPT_DROP_ALIGN(1), .OPT_LOWPOWER(0), .CW(16)) u_rep (
    .i_clk(clk), .i_reset(rst), .i_valid(vin), .i_primitive(pin), .i_data(din),
    .o_valid(ov[1]), .o_keep(ok[1]), .o_primitive(op[1]), .o_data(od[1]),
    .o_cont_active(oa[1]), .o_err_orphan(oe[1]), .o_nsuppressed(oc1));
  satalnk_rmcont_mw #(.NW(2), .OPT_REPEAT(0), .OPT_DROP_ALIGN(1), .OPT_LOWPOWER(0), .CW(4)) u_sat (
    .i_clk(clk), .i_reset(rst), .i_valid(vin), .i_primitive(pin), .i_data(din),
    .o_valid(ov[2]), .o_keep(ok[2]), .o_primitive(op[2]), .o_data(od[2]),
    .o_cont_active(oa[2]), .o_err_orphan(oe[2]), .o_nsuppressed(oc2));
  satalnk_rmcont_mw #(.NW(2), .OPT_REPEAT(0), .OPT_DROP_ALIGN(0), .OPT_LOWPOWER(1), .CW(16)) u_lp (
    .i_clk(clk), .i_reset(rst), .i_valid(vin), .i_primitive(pin), .i_data(din),
    .o_valid(ov[3]), .o_keep(ok[3]), .o_primitive(op[3]), .o_data(od[3]),
    .o_cont_active(oa[3]), .o_err_orphan(oe[3]), .o_nsuppressed(oc3));

  function automatic logic [63:0] act_cnt(input int c);
    case (c)
      0:       return {48'd0, oc0};
      1:       return {48'd0, oc1};
      2:       return {60'd0, oc2};
      default: return {48'd0, oc3};
    endcase
  endfunction

  task automatic chk(input string nm, input int c, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s dut%0d got %h want %h", nm, c, a, e);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_act[c] = 1'b0; m_have[c] = 1'b0; m_last[c] = 32'd0; m_cnt[c] = 0;
      en[c] = '{v: 1'b0, k: 2'b00, p: 2'b00, d: 64'd0, a: 1'b0, o: 1'b0, c: 0};
    end
  endtask

  // Word-stream model: each lane is one word in time order; a CONT run swallows words
  // until the next non-ALIGN, non-CONT primitive.
  task automatic model_step(input bit bv, input logic [1:0] bp, input logic [63:0] bd);
    for (int c = 0; c < 4; c++) begin
      bit rep;
      bit dropal;
      int cmax;
      int n;
      rep    = (c == 1);
      dropal = (c != 3);
      cmax   = (c == 2) ? 15 : 65535;
      n      = 0;
      en[c] = '{v: 1'b0, k: 2'b00, p: 2'b00, d: 64'd0, a: m_act[c], o: 1'b0, c: m_cnt[c]};
      if (bv) begin
        for (int l = 0; l < 2; l++) begin
          logic [31:0] w;
          w = bd[32*l +: 32];
          if (bp[l] && w == P_ALIGN) begin
            if (!dropal) begin
              en[c].k[l] = 1'b1; en[c].p[l] = 1'b1; en[c].d[32*l +: 32] = w;
            end
          end else if (bp[l] && w == P_CONT) begin
            if (!m_have[c]) begin
              en[c].o = 1'b1;
            end else begin
              m_act[c] = 1'b1;
              if (rep) begin
                en[c].k[l] = 1'b1; en[c].p[l] = 1'b1; en[c].d[32*l +: 32] = m_last[c];
              end else begin
                n++;
              end
            end
          end else if (bp[l]) begin
            m_act[c] = 1'b0; m_have[c] = 1'b1; m_last[c] = w;
            en[c].k[l] = 1'b1; en[c].p[l] = 1'b1; en[c].d[32*l +: 32] = w;
          end else if (m_act[c]) begin
            if (rep) begin
              en[c].k[l] = 1'b1; en[c].p[l] = 1'b1; en[c].d[32*l +: 32] = m_last[c];
            end else begin
              n++;
            end
          end else begin
            en[c].k[l] = 1'b1; en[c].d[32*l +: 32] = w;
          end
        end
        m_cnt[c] = (m_cnt[c] + n > cmax) ? cmax : m_cnt[c] + n;
        en[c].v = |en[c].k;
        en[c].a = m_act[c];
        en[c].c = m_cnt[c];
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) ec[c] = en[c];
    chk_en = 1'b1;
  endtask

  task automatic beat(input bit bv, input logic [1:0] bp, input logic [63:0] bd);
    rst = 1'b0; vin = bv; pin = bp; din = bd;
    model_step(bv, bp, bd);
    advance();
  endtask

  task automatic do_reset();
    rst = 1'b1; vin = 1'b0; pin = 2'b00; din = 64'd0;
    model_reset();
    advance();
    rst = 1'b0;
  endtask

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int c = 0; c < 4; c++) begin
        chk("valid",   c, {63'd0, ov[c]}, {63'd0, ec[c].v});
        chk("keep",    c, {62'd0, ok[c]}, {62'd0, ec[c].k});
        chk("cont",    c, {63'd0, oa[c]}, {63'd0, ec[c].a});
        chk("orphan",  c, {63'd0, oe[c]}, {63'd0, ec[c].o});
        chk("nsupp",   c, act_cnt(c), 64'(ec[c].c));
        for (int l = 0; l < 2; l++) begin
          if (ec[c].k[l]) begin
            chk("prim", c, {63'd0, op[c][l]}, {63'd0, ec[c].p[l]});
            chk("data", c, {32'd0, od[c][32*l +: 32]}, {32'd0, ec[c].d[32*l +: 32]});
          end
        end
        if (c == 3) chk("lp_data", c, od[c], ec[c].d);
      end
    end
  end

  initial begin
    do_reset();
    do_reset();
    chk("lit_rst_valid", 0, {63'd0, ov[0]}, 64'd0);
    chk("lit_rst_data", 0, od[0], 64'd0);
    chk("lit_rst_cnt", 0, act_cnt(0), 64'd0);

    beat(1'b1, 2'b11, {P_CONT, P_HOLD});
    chk("lit_t1_keep", 0, {62'd0, ok[0]}, 64'd1);
    chk("lit_t1_lane0", 0, {32'd0, od[0][31:0]}, {32'd0, P_HOLD});
    chk("lit_t1_keep", 1, {62'd0, ok[1]}, 64'd3);
    chk("lit_t1_lane1", 1, {32'd0, od[1][63:32]}, {32'd0, P_HOLD});
    beat(1'b1, 2'b00, {32'h9ABC_DEF0, 32'h1234_5678});
    chk("lit_t2_valid", 0, {63'd0, ov[0]}, 64'd0);
    chk("lit_t2_cnt", 0, act_cnt(0), 64'd3);
    chk("lit_t2_cont", 0, {63'd0, oa[0]}, 64'd1);
    chk("lit_t2_data", 1, od[1], {P_HOLD, P_HOLD});
    chk("lit_t2_prim", 1, {62'd0, op[1]}, 64'd3);
    chk("lit_t2_cnt", 1, act_cnt(1), 64'd0);

    beat(1'b1, 2'b01, {32'h1111_1111, P_ALIGN});
    chk("lit_al_keep", 0, {62'd0, ok[0]}, 64'd0);
    chk("lit_al_keep", 3, {62'd0, ok[3]}, 64'd1);
    beat(1'b1, 2'b10, {P_XRDY, 32'h2222_2222});
    chk("lit_xrdy_keep", 0, {62'd0, ok[0]}, 64'd2);
    chk("lit_xrdy_cont", 0, {63'd0, oa[0]}, 64'd0);
    beat(1'b0, 2'b11, {P_CONT, P_CONT});
    chk("lit_idle_cnt", 0, act_cnt(0), 64'd5);

    do_reset();
    beat(1'b1, 2'b11, {P_CONT, P_CONT});
    chk("lit_orph", 0, {63'd0, oe[0]}, 64'd1);
    chk("lit_orph_keep", 0, {62'd0, ok[0]}, 64'd0);
    beat(1'b1, 2'b00, {32'h4444_4444, 32'h3333_3333});
    chk("lit_orph_pulse", 0, {63'd0, oe[0]}, 64'd0);
    chk("lit_orph_next", 0, {62'd0, ok[0]}, 64'd3);

    beat(1'b1, 2'b11, {P_CONT, P_SYNC});
    for (int i = 0; i < 10; i++) begin
      beat(1'b1, 2'b00, {32'hA000_0000 + 32'(i), 32'h5000_0000 + 32'(i)});
      if (i == 4) chk("lit_sat_mid", 2, act_cnt(2), 64'd11);
    end
    chk("lit_sat", 2, act_cnt(2), 64'd15);
    chk("lit_unsat", 0, act_cnt(0), 64'd21);
    chk("lit_pre_rst_cont", 0, {63'd0, oa[0]}, 64'd1);

    do_reset();
    chk("lit_mid_rst_cont", 0, {63'd0, oa[0]}, 64'd0);
    chk("lit_mid_rst_data", 1, od[1], 64'd0);
    chk("lit_mid_rst_keep", 1, {62'd0, ok[1]}, 64'd0);
    beat(1'b1, 2'b00, {32'h6666_6666, 32'h5555_5555});
    chk("lit_post_rst_keep", 0, {62'd0, ok[0]}, 64'd3);

    beat(1'b1, 2'b11, {P_CONT, P_SYNC});
    beat(1'b1, 2'b11, {P_SYNC, P_CONT});
    chk("lit_order_keep", 0, {62'd0, ok[0]}, 64'd2);
    chk("lit_order_cont", 0, {63'd0, oa[0]}, 64'd0);
    beat(1'b1, 2'b00, {32'h8888_8888, 32'h7777_7777});
    chk("lit_order_data", 0, od[0], 64'h8888_8888_7777_7777);
    beat(1'b1, 2'b11, {P_ALIGN, P_CONT});
    beat(1'b1, 2'b00, {32'hBBBB_BBBB, 32'hAAAA_AAAA});
    beat(1'b0, 2'b00, 64'd0);
    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
